// File: rtl/tc21073_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tc21073_sub_seq
// Purpose  : Byte-serial adder/subtractor. An NBYTES-wide add or subtract is
//            computed through a single 8-bit slice, one byte per cycle, LSB
//            first. Subtract is a + ~b + 1 (carry seeded with 1).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   begin an operation (accepted in IDLE or DONE only)
//   op     in   0 = a - b, 1 = a + b
//   a, b   in   operands, 8*NBYTES bits
//   busy   out  high during the NBYTES RUN cycles
//   done   out  one-cycle pulse, result valid
//   sum    out  result, 8*NBYTES bits
//   cout   out  final carry (subtract: 1 = no borrow)
//   ovf    out  two's-complement overflow
//   zero   out  sum is all zeros
// ============================================================================
module tc21073_sub_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  zero
);

  localparam int W    = 8 * NBYTES;
  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_op;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;

  logic            w_accept;
  logic            w_last;
  logic [W-1:0]    w_a_sh;
  logic [W-1:0]    w_b_sh;
  logic [7:0]      w_a_byte;
  logic [7:0]      w_beff;
  logic [8:0]      w_slice;

  // Start is honoured whenever no operation is in flight.
  assign w_accept = start && (r_state != RUN);
  assign w_last   = (r_idx == LAST_IDX);

  // Current byte selected by shifting the latched operand down.
  assign w_a_sh   = r_a >> {r_idx, 3'b000};
  assign w_b_sh   = r_b >> {r_idx, 3'b000};
  assign w_a_byte = w_a_sh[7:0];
  assign w_beff   = r_op ? w_b_sh[7:0] : ~w_b_sh[7:0];
  assign w_slice  = {1'b0, w_a_byte} + {1'b0, w_beff} + {8'd0, r_carry};

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        // A start held in DONE chains straight into the next operation.
        w_state_nxt = start ? RUN : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= 1'b0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_op    <= op;
      r_idx   <= '0;
      // Subtract supplies the +1 of the two's complement through the carry.
      r_carry <= ~op;
    end else if (r_state == RUN) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (r_idx == IDXW'(i)) r_sum[8*i +: 8] <= w_slice[7:0];
      end
      r_carry <= w_slice[8];
      r_idx   <= r_idx + IDXW'(1);
      if (w_last) begin
        r_cout <= w_slice[8];
        // Overflow: operands of equal sign give a result of the other sign.
        r_ovf  <= (w_a_byte[7] == w_beff[7]) && (w_slice[7] != w_a_byte[7]);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = (r_sum == '0);

endmodule
`default_nettype wire

// File: tb/tb_tc21073_sub_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc21073_sub_seq
// Purpose  : Scoreboard bench for tc21073_sub_seq (NBYTES = 4). Stimulus pushes
//            expected results computed with whole-word arithmetic; a monitor
//            pops and compares on every done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc21073_sub_seq;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;

  tc21073_sub_seq #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word unsigned arithmetic plus sign rules.
  function automatic exp_t model(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t        e;
    logic [W:0]  full;
    if (o) full = {1'b0, x} + {1'b0, y};
    else   full = {1'b0, x} + {1'b0, ~y} + 1;
    e.sum  = full[W-1:0];
    e.cout = full[W];
    if (o) e.ovf = (x[W-1] == y[W-1]) && (e.sum[W-1] != x[W-1]);
    else   e.ovf = (x[W-1] != y[W-1]) && (e.sum[W-1] != x[W-1]);
    e.zero = (e.sum == '0);
    e.due  = 0;
    return e;
  endfunction

  // Monitor: busy length and result checks on every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        busy_run++;
      end else begin
        if (done) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL spurious_done: got done=1 expected no pending result (t=%0t)", $time);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sum",       64'(sum),      64'(e.sum));
            check("cout",      64'(cout),     64'(e.cout));
            check("ovf",       64'(ovf),      64'(e.ovf));
            check("zero",      64'(zero),     64'(e.zero));
            check("latency",   64'(cyc),      64'(e.due));
            check("busy_len",  64'(busy_run), 64'(NB));
          end
        end
        busy_run = 0;
      end
    end else begin
      busy_run = 0;
    end
  end

  // Caller is positioned just after a negedge. mode 0: plain, 1: re-pulse
  // start in RUN cycles 2-3, 2: hold start for the whole RUN. Returns at the
  // negedge of the DONE cycle.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input int mode);
    exp_t e;
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    e     = model(o, x, y);
    e.due = cyc + NB + 1;
    sb.push_back(e);
    for (int i = 1; i <= NB; i++) begin
      @(negedge clk);
      start = (mode == 2) || ((mode == 1) && (i == 2 || i == 3));
      op    = 1'($urandom);
      a     = W'($urandom);
      b     = W'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_sum"},  64'(sum),  64'd0);
    check({tag, "_cout"}, 64'(cout), 64'd0);
    check({tag, "_ovf"},  64'(ovf),  64'd0);
    check({tag, "_zero"}, 64'(zero), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;
    #3 rst_n = 1'b0;
    #1 check_reset_state("rst");
    repeat (2) @(negedge clk);
    check_reset_state("rst_clk");

    // Release reset and start on the same cycle: first edge must accept.
    rst_n = 1'b1;
    issue(1'b0, 32'h0000_0005, 32'h0000_0003, 0);
    start = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h0000_0000, 32'h0000_0001, 0);
    start = 1'b0;
    @(negedge clk);
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    start = 1'b0;
    @(negedge clk);
    issue(1'b0, 32'h8000_0000, 32'h0000_0001, 0);
    start = 1'b0;
    @(negedge clk);
    issue(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    start = 1'b0;
    @(negedge clk);

    // Start re-pulsed mid-RUN with other operands must be ignored.
    issue(1'b1, 32'h1234_5678, 32'h1111_1111, 1);
    start = 1'b0;
    @(negedge clk);

    // Start held high through RUN and DONE: chained ops, no IDLE cycle.
    issue(1'b0, 32'h0000_0100, 32'h0000_0001, 2);
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 2);
    issue(1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
    start = 1'b0;
    @(negedge clk);

    // Reset during RUN cycle 2 aborts the operation without a done pulse.
    start = 1'b1;
    op    = 1'b1;
    a     = 32'hAAAA_AAAA;
    b     = 32'h5555_5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midrun");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b0, 32'h0000_0010, 32'h0000_0020, 0);
    start = 1'b0;
    @(negedge clk);

    // Random operations with random gaps (gap 0 = back-to-back).
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      int           gap;
      ra = W'($urandom);
      rb = (($urandom % 4) == 0) ? ra : W'($urandom);
      issue(1'($urandom), ra, rb, int'($urandom_range(0, 1)));
      gap = int'($urandom_range(0, 2));
      if (gap > 0) begin
        start = 1'b0;
        repeat (gap) @(negedge clk);
      end
    end
    start = 1'b0;
    repeat (NB + 3) @(negedge clk);
    check("drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc21073_sub_seq.md
TC21073_SUB_SEQ -- requirements
Module: tc21073_sub_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, meaning the operand width in bytes (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to begin an operation.
REQ-005 SHALL have port op, input, 1: 0 = subtract (a-b), 1 = add (a+b).
REQ-006 SHALL have port a, input, 8*NBYTES, minuend/addend A.
REQ-007 SHALL have port b, input, 8*NBYTES, subtrahend/addend B.
REQ-008 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port done, output, 1, one-cycle pulse when the result is valid.
REQ-010 SHALL have port sum, output, 8*NBYTES, the result.
REQ-011 SHALL have port cout, output, 1, final carry; for subtract, 1 = no borrow (a>=b unsigned).
REQ-012 SHALL have port ovf, output, 1, two's-complement signed overflow.
REQ-013 SHALL have port zero, output, 1, high when sum is all zeros.

Function
REQ-014 SHALL perform the full-width operation serially through one 8-bit slice computing a_byte + (op ? b_byte : ~b_byte) + c, one byte per cycle, LSB first.
REQ-015 SHALL use states IDLE, RUN, DONE; encoding is free.
REQ-016 SHALL accept start only in IDLE or DONE: latch a, b and op, clear byte index to 0, set carry to 1 for subtract or 0 for add, and enter RUN.
REQ-017 SHALL ignore start while in RUN, leaving the latched operands and progress unchanged.
REQ-018 In RUN, each cycle SHALL write the slice output into sum byte[idx], register the slice carry-out as the next carry, and increment idx.
REQ-019 SHALL leave RUN for DONE after the cycle that processes byte NBYTES-1, i.e. exactly NBYTES RUN cycles.
REQ-020 SHALL assert busy for exactly the RUN cycles.
REQ-021 SHALL assert done only during the single DONE cycle, which is NBYTES+1 cycles after the start-accept edge.
REQ-022 SHALL move DONE to IDLE when start=0, or DONE to RUN when start=1 (back-to-back operation).
REQ-023 SHALL take cout as the carry-out of byte NBYTES-1.
REQ-024 SHALL compute ovf as (a_msb == beff_msb) && (sum_msb != a_msb), where beff is b for add and ~b for subtract.
REQ-025 SHALL update cout and ovf on the final RUN cycle.
REQ-026 SHALL derive zero combinationally from sum.
REQ-027 SHALL hold sum, cout and ovf stable from DONE until the next accepted start.
REQ-028 SHALL give sum, cout and ovf unspecified partial contents while busy; consumers sample only on done.
REQ-029 SHALL ignore changes on the a, b and op inputs after the start-accept edge.

Reset
REQ-030 SHALL, on rst_n low, asynchronously force IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, idx=0, carry=0; zero therefore reads 1.
REQ-031 SHALL abort an operation in progress when reset is asserted mid-RUN, with no done pulse afterwards.
REQ-032 SHALL accept start on the first rising edge after rst_n deasserts.

Verification (NBYTES=4)
REQ-033 SHALL cover: sub a=0x00000005, b=0x00000003 -> after 5 cycles done=1, sum=0x00000002, cout=1, ovf=0, zero=0.
REQ-034 SHALL cover: sub a=0x00000000, b=0x00000001 -> sum=0xFFFFFFFF, cout=0, ovf=0.
REQ-035 SHALL cover: add a=0xFFFFFFFF, b=0x00000001 -> sum=0x00000000, cout=1, zero=1, ovf=0.
REQ-036 SHALL cover: sub a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, ovf=1, cout=1.
REQ-037 SHALL cover: start pulsed again during cycles 2-3 of RUN with different operands -> ignored; the original result is delivered at cycle 5 and busy stays high 4 cycles.
REQ-038 SHALL cover: rst_n low during RUN cycle 2 -> outputs reset immediately (zero=1), no done; a new start afterwards completes normally. Also: start held high in DONE -> next operation begins with no IDLE cycle.
